int_gen_burst: RTL

INT_GEN_BURST -- requirements
Module: int_gen_burst

---
 rtl/int_gen_burst.sv | 137 +++++++++++++
 1 files changed

// File: rtl/int_gen_burst.sv
// Interrupter gate generator: periodic pulses with a duty-capped width and
// optional ON/OFF bursting, compiled in when INT_GEN_BURST_EN is defined.
module int_gen_burst #(
    parameter int CLK_MHZ     = 100,
    parameter int FREQ_MIN_HZ = 10_000,
    parameter int PERIOD_STEP = 32,
    parameter int PW_STEP_MUL = 1,
    parameter int PAR_MAX_VAL = 255,
    parameter int DUTY_NUM    = 26,
    localparam int PAR_W      = $clog2(PAR_MAX_VAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PAR_W-1:0] freq_par,
    input  logic [PAR_W-1:0] pw_par,
    input  logic [PAR_W-1:0] burst_on_par,
    input  logic [PAR_W-1:0] burst_off_par,
    output logic             out,
    output logic             sync
);
    localparam int PERIOD_MAX = 1_000_000 * CLK_MHZ / FREQ_MIN_HZ;
    localparam int PH_W       = $clog2(PERIOD_MAX + 1);

    if (PERIOD_STEP * PAR_MAX_VAL >= PERIOD_MAX) begin : g_bad_period
        $fatal(1, "int_gen_burst: PERIOD_STEP*PAR_MAX_VAL must be below PERIOD_MAX");
    end

`ifdef INT_GEN_BURST_EN
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
`else
    typedef enum logic [0:0] {IDLE, ON} state_t;
`endif

    state_t          state;
    state_t          burst_state;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] period_lat;
    logic [PH_W-1:0] width_lat;
    logic [PH_W-1:0] period_nxt;
    logic [PH_W-1:0] width_nxt;
    logic [31:0]     period_full;
    logic [31:0]     pw_req;
    logic [31:0]     pw_cap;
    logic            period_end;

    // Width is clamped at full 32-bit precision before narrowing to the counter width.
    always_comb begin
        period_full = 32'(PERIOD_MAX) - 32'(PERIOD_STEP) * 32'(freq_par);
        pw_req      = 32'(PW_STEP_MUL) * 32'(pw_par);
        pw_cap      = (period_full * 32'(DUTY_NUM)) >> 8;
        period_nxt  = PH_W'(period_full);
        width_nxt   = PH_W'((pw_req < pw_cap) ? pw_req : pw_cap);
    end

    assign period_end = (phase == period_lat - PH_W'(1));

`ifdef INT_GEN_BURST_EN
    logic [PAR_W-1:0] burst_on_lat;
    logic [PAR_W-1:0] burst_off_lat;
    logic [PAR_W-1:0] burst_cnt;
    logic [PAR_W-1:0] burst_cnt_nxt;
    logic [PAR_W:0]   done_cnt;
    logic [PAR_W:0]   on_eff;

    // State and count that take effect at the coming period start.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        done_cnt      = {1'b0, burst_cnt} + (PAR_W+1)'(1);
        on_eff        = (burst_on_lat == '0) ? (PAR_W+1)'(1) : {1'b0, burst_on_lat};
        burst_state   = ON;
        burst_cnt_nxt = '0;
        case (state)
            ON: begin
                if (burst_off_lat != '0 && done_cnt >= on_eff) begin
                    burst_state = OFF;
                end else if (burst_off_lat != '0) begin
                    burst_cnt_nxt = done_cnt[PAR_W-1:0];
                end
            end
            OFF: begin
                if (done_cnt < {1'b0, burst_off_lat}) begin
                    burst_state   = OFF;
                    burst_cnt_nxt = done_cnt[PAR_W-1:0];
                end
            end
            default: ;
        endcase
    end
`else
    logic unused_burst;
    assign unused_burst = ^{burst_on_par, burst_off_par};
    assign burst_state  = ON;
`endif

    // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            period_lat <= '0;
            width_lat  <= '0;
            out        <= 1'b0;
            sync       <= 1'b0;
`ifdef INT_GEN_BURST_EN
            burst_on_lat  <= '0;
            burst_off_lat <= '0;
            burst_cnt     <= '0;
`endif
        end else if (!en) begin
            state <= IDLE;
            phase <= '0;
            out   <= 1'b0;
            sync  <= 1'b0;
`ifdef INT_GEN_BURST_EN
            burst_cnt <= '0;
`endif
        end else if (state == IDLE || period_end) begin
            state      <= burst_state;
            phase      <= '0;
            period_lat <= period_nxt;
            width_lat  <= width_nxt;
            out        <= (burst_state == ON) && (width_nxt != '0);
            sync       <= 1'b1;
`ifdef INT_GEN_BURST_EN
            burst_on_lat  <= burst_on_par;
            burst_off_lat <= burst_off_par;
            burst_cnt     <= burst_cnt_nxt;
`endif
        end else begin
            phase <= phase + PH_W'(1);
            out   <= (state == ON) && (phase + PH_W'(1) < width_lat);
            sync  <= 1'b0;
        end
    end

endmodule
